l2_bus_arbiter: RTL and testbench

- Round-robin arbiter placed directly upstream of the shared L2 cache slave port.
- Collects requests from NUM_MASTERS L1 caches (I$/D$ of each core) and forwards exactly one at a time onto the single-outstanding L2 interface (addr/wdata/be/we/en → rdata/ready).
- Holds each grant from first forwarded cycle until the L2 returns ready; then rotates priority.

---
 rtl/l2_bus_pkg.sv | 20 ++
 rtl/l2_bus_if.sv | 35 +++
 rtl/l2_bus_arbiter_rr_priority_picker.sv | 32 +++
 rtl/l2_bus_arbiter.sv | 129 ++++++++++++
 tb/tb_l2_bus_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l2_bus_pkg.sv
// Shared L2 bus definitions: arbiter state encoding and the address/data/byte
// enable widths also used by l2_cache.
package l2_bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Round-robin index wrap for counts that need not be a power of two.
  // Callers guarantee idx < 2*n, so a single subtraction is enough.
  function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
    return (idx >= n) ? (idx - n) : idx;
  endfunction

endpackage

// File: rtl/l2_bus_if.sv
// L1-to-L2 arbitration bus. The slave modport is the arbiter's view (it serves
// the L1 masters and drives the L2 port); the master modport is the
// environment's view (L1 requesters plus the L2 responder).
interface l2_bus_if #(
  parameter int unsigned NUM_MASTERS = 2
) ();
  import l2_bus_pkg::*;

  logic [NUM_MASTERS*ADDR_W-1:0] m_addr;
  logic [NUM_MASTERS*DATA_W-1:0] m_wdata;
  logic [NUM_MASTERS*BE_W-1:0]   m_be;
  logic [NUM_MASTERS-1:0]        m_we;
  logic [NUM_MASTERS-1:0]        m_en;
  logic [NUM_MASTERS*DATA_W-1:0] m_rdata;
  logic [NUM_MASTERS-1:0]        m_ready;

  logic [ADDR_W-1:0]             s_addr;
  logic [DATA_W-1:0]             s_wdata;
  logic [BE_W-1:0]               s_be;
  logic                          s_we;
  logic                          s_en;
  logic [DATA_W-1:0]             s_rdata;
  logic                          s_ready;

  modport slave (
    input  m_addr, m_wdata, m_be, m_we, m_en, s_rdata, s_ready,
    output m_rdata, m_ready, s_addr, s_wdata, s_be, s_we, s_en
  );

  modport master (
    output m_addr, m_wdata, m_be, m_we, m_en, s_rdata, s_ready,
    input  m_rdata, m_ready, s_addr, s_wdata, s_be, s_we, s_en
  );

endinterface

// File: rtl/l2_bus_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: returns the first asserted request found
// scanning upward from i_ptr with wrap. Kept standalone so a memory-side
// arbiter can reuse it.
module rr_priority_picker
  import l2_bus_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned IDX_BITS = 1
) (
  input  logic [NUM_REQ-1:0]  i_req,
  input  logic [IDX_BITS-1:0] i_ptr,
  output logic [IDX_BITS-1:0] o_winner,
  output logic                o_valid
);

  logic [2*NUM_REQ-1:0] w_rot;

  // Rotate the request vector so position 0 is the current priority holder,
  // then take the lowest set bit and map it back to a master index.
  always_comb begin
    w_rot    = {i_req, i_req} >> i_ptr;
    o_winner = '0;
    o_valid  = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!o_valid && w_rot[k]) begin
        o_valid  = 1'b1;
        o_winner = IDX_BITS'(rr_wrap(int'(i_ptr) + k, NUM_REQ));
      end
    end
  end

endmodule

// File: rtl/l2_bus_arbiter.sv
// Round-robin arbiter in front of the single-outstanding L2 slave port.
// One grant is held from the first forwarded cycle until the L2 returns
// s_ready, then priority rotates to grant+1.
// Optional build macro L2_ARB_STATS_EN adds per-master grant and wait counters
// (stat_grants, stat_wait); arbitration timing is the same either way.
module l2_bus_arbiter
  import l2_bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned IDX_BITS    = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  l2_bus_if.slave                     bus
`ifdef L2_ARB_STATS_EN
  ,
  output logic [NUM_MASTERS*32-1:0]   stat_grants,
  output logic [NUM_MASTERS*32-1:0]   stat_wait
`endif
);

  arb_state_e            r_state;
  logic [IDX_BITS-1:0]   r_grant;
  logic [IDX_BITS-1:0]   r_rr_ptr;
  logic [IDX_BITS-1:0]   w_winner;
  logic                  w_valid;
  logic [IDX_BITS-1:0]   w_grant_next;

  rr_priority_picker #(
    .NUM_REQ  (NUM_MASTERS),
    .IDX_BITS (IDX_BITS)
  ) u_picker (
    .i_req    (bus.m_en),
    .i_ptr    (r_rr_ptr),
    .o_winner (w_winner),
    .o_valid  (w_valid)
  );

  // Priority after a completion: one past the finished master, wrapping
  // explicitly so non-power-of-two master counts never index past the end.
  always_comb begin
    w_grant_next = IDX_BITS'(rr_wrap(int'(r_grant) + 1, NUM_MASTERS));
  end

  // Arbitration FSM: pick in IDLE, hold the grant in BUSY until s_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ARB_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_valid) begin
            r_grant <= w_winner;
            r_state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (bus.s_ready) begin
            r_rr_ptr <= w_grant_next;
            r_state  <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  // Forward the granted master to L2 and route the response back. Driven
  // straight from state so a reset drops s_en at once and an L2 hit can
  // complete in the first BUSY cycle. A dropped m_en keeps the grant but
  // forwards s_en=0, since L2 may still be refilling from s_addr.
  always_comb begin
    bus.s_addr  = '0;
    bus.s_wdata = '0;
    bus.s_be    = '0;
    bus.s_we    = 1'b0;
    bus.s_en    = 1'b0;
    bus.m_ready = '0;
    bus.m_rdata = '0;
    if (r_state == ARB_BUSY) begin
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        if (r_grant == IDX_BITS'(i)) begin
          bus.s_addr                       = bus.m_addr[i*ADDR_W +: ADDR_W];
          bus.s_wdata                      = bus.m_wdata[i*DATA_W +: DATA_W];
          bus.s_be                         = bus.m_be[i*BE_W +: BE_W];
          bus.s_we                         = bus.m_we[i];
          bus.s_en                         = bus.m_en[i];
          bus.m_ready[i]                   = bus.s_ready;
          bus.m_rdata[i*DATA_W +: DATA_W]  = bus.s_rdata;
        end
      end
    end
  end

`ifdef L2_ARB_STATS_EN
  logic [31:0] r_stat_grants [NUM_MASTERS];
  logic [31:0] r_stat_wait   [NUM_MASTERS];

  // Count grants on IDLE->BUSY and every requesting cycle not being served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        r_stat_grants[i] <= '0;
        r_stat_wait[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        if (r_state == ARB_IDLE && w_valid && w_winner == IDX_BITS'(i))
          r_stat_grants[i] <= r_stat_grants[i] + 32'd1;
        if (bus.m_en[i] && !(r_state == ARB_BUSY && r_grant == IDX_BITS'(i)))
          r_stat_wait[i] <= r_stat_wait[i] + 32'd1;
      end
    end
  end

  // Pack the counters onto the flat output buses.
  always_comb begin
    stat_grants = '0;
    stat_wait   = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      stat_grants[i*32 +: 32] = r_stat_grants[i];
      stat_wait[i*32 +: 32]   = r_stat_wait[i];
    end
  end
`endif

endmodule

// File: tb/tb_l2_bus_arbiter.sv
// Self-checking bench for l2_bus_arbiter with three masters (non-power-of-two
// wrap). A behavioural model predicts every output each cycle; directed
// scenarios add literal expectations; a randomized phase follows.
module tb_l2_bus_arbiter;
  import l2_bus_pkg::*;

  localparam int N    = 3;
  localparam int IDXB = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  l2_bus_if #(.NUM_MASTERS(N)) bus ();

`ifdef L2_ARB_STATS_EN
  logic [N*32-1:0] stat_grants;
  logic [N*32-1:0] stat_wait;
`endif

  l2_bus_arbiter #(
    .NUM_MASTERS (N),
    .IDX_BITS    (IDXB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef L2_ARB_STATS_EN
    ,
    .stat_grants (stat_grants),
    .stat_wait   (stat_wait)
`endif
  );

  // Stimulus
  logic [31:0]  tb_addr  [N];
  logic [31:0]  tb_wdata [N];
  logic [3:0]   tb_be    [N];
  logic [N-1:0] tb_we;
  logic [N-1:0] tb_en;
  logic         tb_sready;
  logic [31:0]  tb_srdata;

  // Model
  bit          mdl_busy;
  int          mdl_grant;
  int          mdl_ptr;
  int unsigned mdl_sg [N];
  int unsigned mdl_sw [N];

  // Samples of the last cycle
  logic          smp_en, smp_we;
  logic [31:0]   smp_addr, smp_wdata;
  logic [3:0]    smp_be;
  logic [N-1:0]  smp_rdy;
  logic [N*32-1:0] smp_rdata;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mdl_busy  = 1'b0;
    mdl_grant = 0;
    mdl_ptr   = 0;
    for (int i = 0; i < N; i++) begin
      mdl_sg[i] = 0;
      mdl_sw[i] = 0;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.m_addr[i*32 +: 32]  = tb_addr[i];
      bus.m_wdata[i*32 +: 32] = tb_wdata[i];
      bus.m_be[i*4 +: 4]      = tb_be[i];
    end
    bus.m_we    = tb_we;
    bus.m_en    = tb_en;
    bus.s_ready = tb_sready;
    bus.s_rdata = tb_srdata;
  endtask

  // One clock cycle: entered at posedge+1, drive, check at +2, advance model,
  // return at the next posedge+1.
  task automatic cycle();
    logic [31:0]     e_addr, e_wdata;
    logic [3:0]      e_be;
    logic            e_we, e_en;
    logic [N-1:0]    e_rdy;
    logic [N*32-1:0] e_rdata;
    drive();
    #1;
    e_addr = '0; e_wdata = '0; e_be = '0; e_we = 1'b0; e_en = 1'b0;
    e_rdy = '0; e_rdata = '0;
    if (mdl_busy) begin
      e_addr  = tb_addr[mdl_grant];
      e_wdata = tb_wdata[mdl_grant];
      e_be    = tb_be[mdl_grant];
      e_we    = tb_we[mdl_grant];
      e_en    = tb_en[mdl_grant];
      e_rdy[mdl_grant] = tb_sready;
      e_rdata[mdl_grant*32 +: 32] = tb_srdata;
    end
    chk("s_addr",  128'(bus.s_addr),  128'(e_addr));
    chk("s_wdata", 128'(bus.s_wdata), 128'(e_wdata));
    chk("s_be",    128'(bus.s_be),    128'(e_be));
    chk("s_we",    128'(bus.s_we),    128'(e_we));
    chk("s_en",    128'(bus.s_en),    128'(e_en));
    chk("m_ready", 128'(bus.m_ready), 128'(e_rdy));
    chk("m_rdata", 128'(bus.m_rdata), 128'(e_rdata));
`ifdef L2_ARB_STATS_EN
    for (int i = 0; i < N; i++) begin
      chk("stat_grants", 128'(stat_grants[i*32 +: 32]), 128'(mdl_sg[i]));
      chk("stat_wait",   128'(stat_wait[i*32 +: 32]),   128'(mdl_sw[i]));
    end
`endif
    smp_en = bus.s_en; smp_we = bus.s_we; smp_addr = bus.s_addr;
    smp_wdata = bus.s_wdata; smp_be = bus.s_be; smp_rdy = bus.m_ready;
    smp_rdata = bus.m_rdata;
    // Advance the model by one clock
    for (int i = 0; i < N; i++)
      if (tb_en[i] && !(mdl_busy && mdl_grant == i)) mdl_sw[i]++;
    if (!mdl_busy) begin
      for (int off = 0; off < N; off++) begin
        int c;
        c = (mdl_ptr + off) % N;
        if (tb_en[c]) begin
          mdl_grant = c;
          mdl_busy  = 1'b1;
          mdl_sg[c]++;
          break;
        end
      end
    end else if (tb_sready) begin
      mdl_ptr  = (mdl_grant + 1) % N;
      mdl_busy = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  int  exp_seq [8] = '{0, 2, 0, 1, 0, 2, 0, 1};
  bit  pending [N];
  int  wait_txn [N];
  int  l2_wait;
  bit  busy_seen;
  bit  pre_busy;
  int  pre_g;

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      tb_addr[i] = '0; tb_wdata[i] = '0; tb_be[i] = '0;
    end
    tb_we = '0; tb_en = '0; tb_sready = 1'b0; tb_srdata = '0;
    drive();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("in_reset_s_en", 128'(bus.s_en), 128'(0));
    rst_n = 1'b1;

    // Reset state
    cycle();
    chk("reset_s_en", 128'(smp_en), 128'(0));
    chk("reset_m_ready", 128'(smp_rdy), 128'(0));

    // Single read hit: ready two cycles after request
    tb_en = 3'b001; tb_addr[0] = 32'h0000_1000;
    cycle();
    chk("single_arb_s_en", 128'(smp_en), 128'(0));
    tb_sready = 1'b1; tb_srdata = 32'hDEAD_BEEF;
    cycle();
    chk("single_m_ready", 128'(smp_rdy), 128'(3'b001));
    chk("single_rdata0", 128'(smp_rdata[31:0]), 128'(32'hDEAD_BEEF));
    chk("single_rdata_other", 128'(smp_rdata[95:32]), 128'(0));
    chk("single_s_addr", 128'(smp_addr), 128'(32'h0000_1000));
    tb_en = '0; tb_sready = 1'b0;
    cycle();

    // Contention between masters 0 and 1 with 1-cycle L2 hits
    tb_en = 3'b011; tb_sready = 1'b1; tb_addr[1] = 32'h0000_1100;
    for (int k = 0; k < 8; k++) begin
      tb_srdata = 32'hA000_0000 + 32'(k);
      cycle();
      chk("contend_m_ready", 128'(smp_rdy), 128'(exp_seq[k]));
      chk("contend_s_en", 128'(smp_en), 128'(k % 2));
    end

    // Long refill: master 0 holds the bus for 6 cycles while master 1 waits
    tb_addr[0] = 32'h0000_3000; tb_addr[1] = 32'h0000_3100;
    tb_en = 3'b001; tb_sready = 1'b0;
    cycle();
    tb_en = 3'b011;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("refill_s_addr", 128'(smp_addr), 128'(32'h0000_3000));
      chk("refill_m_ready", 128'(smp_rdy), 128'(0));
    end
    tb_sready = 1'b1;
    cycle();
    chk("refill_done", 128'(smp_rdy), 128'(3'b001));
    tb_en = 3'b010;
    cycle();
    chk("refill_gap_s_en", 128'(smp_en), 128'(0));
    cycle();
    chk("refill_next_addr", 128'(smp_addr), 128'(32'h0000_3100));
    chk("refill_next_rdy", 128'(smp_rdy), 128'(3'b010));

    // Write forwarding from master 1
    tb_addr[1] = 32'h0000_2004; tb_wdata[1] = 32'h1234_5678; tb_be[1] = 4'b0011;
    tb_we = 3'b010; tb_en = 3'b010; tb_sready = 1'b0;
    cycle();
    tb_sready = 1'b1;
    cycle();
    chk("wr_s_we", 128'(smp_we), 128'(1));
    chk("wr_s_be", 128'(smp_be), 128'(4'b0011));
    chk("wr_s_wdata", 128'(smp_wdata), 128'(32'h1234_5678));
    chk("wr_s_addr", 128'(smp_addr), 128'(32'h0000_2004));
    chk("wr_m_ready", 128'(smp_rdy), 128'(3'b010));
    tb_we = '0;

    // Granted master drops m_en: grant held, s_en forwarded low
    tb_addr[2] = 32'h0000_4000; tb_en = 3'b100; tb_sready = 1'b0;
    cycle();
    cycle();
    chk("drop_s_en_hi", 128'(smp_en), 128'(1));
    tb_en = 3'b000;
    cycle();
    chk("drop_s_en_lo", 128'(smp_en), 128'(0));
    chk("drop_s_addr", 128'(smp_addr), 128'(32'h0000_4000));
    tb_en = 3'b101;
    cycle();
    chk("drop_no_rearb", 128'(smp_addr), 128'(32'h0000_4000));
    tb_sready = 1'b1;
    cycle();
    chk("drop_done", 128'(smp_rdy), 128'(3'b100));
    tb_en = 3'b001;
    cycle();
    cycle();
    chk("m0_after_drop", 128'(smp_rdy), 128'(3'b001));

    // Reset during BUSY (priority pointer is 1 here)
    tb_en = 3'b010; tb_sready = 1'b0;
    cycle();
    drive();
    #1;
    chk("pre_reset_s_en", 128'(bus.s_en), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("async_reset_s_en", 128'(bus.s_en), 128'(0));
    chk("async_reset_m_ready", 128'(bus.m_ready), 128'(0));
    model_reset();
    tb_en = 3'b011; tb_sready = 1'b1;
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (k == 1) chk("post_reset_first_grant", 128'(smp_rdy), 128'(3'b001));
    end
`ifdef L2_ARB_STATS_EN
    chk("stat_grants_lit", 128'(stat_grants), 128'({32'd0, 32'd5, 32'd5}));
    chk("stat_wait_lit",   128'(stat_wait),   128'({32'd0, 32'd15, 32'd15}));
`endif

    // Randomized traffic with variable L2 latency
    tb_en = '0;
    for (int i = 0; i < N; i++) begin
      pending[i] = 1'b0;
      wait_txn[i] = 0;
    end
    busy_seen = 1'b0;
    l2_wait = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pending[i] && $urandom_range(0, 3) == 0) begin
          pending[i]  = 1'b1;
          wait_txn[i] = 0;
          tb_addr[i]  = $urandom;
          tb_wdata[i] = $urandom;
          tb_be[i]    = 4'($urandom_range(0, 15));
          tb_we[i]    = 1'($urandom_range(0, 1));
        end
        tb_en[i] = pending[i];
      end
      if (mdl_busy && !busy_seen) begin
        l2_wait   = int'($urandom_range(0, 3));
        busy_seen = 1'b1;
      end
      tb_sready = mdl_busy ? (l2_wait == 0) : 1'($urandom_range(0, 1));
      tb_srdata = $urandom;
      pre_busy  = mdl_busy;
      pre_g     = mdl_grant;
      cycle();
      if (pre_busy && tb_sready) begin
        chk("fairness", 128'(wait_txn[pre_g] <= N - 1), 128'(1));
        for (int i = 0; i < N; i++)
          if (i != pre_g && pending[i]) wait_txn[i]++;
        pending[pre_g] = 1'b0;
        busy_seen = 1'b0;
      end else if (pre_busy) begin
        l2_wait--;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
